// File: rtl/bus_read_fifo.sv
// bus_read_fifo: source-fed byte FIFO drained by processor bus reads.
// Data port at IO_ADDRESS (read pops the head byte), status/control at
// IO_ADDRESS+1 (read returns {full, empty, overflow, 0, count[3:0]},
// any write flushes the FIFO and clears overflow).
// Optional interrupt logic is built only when BUS_READ_FIFO_IRQ_EN is defined.
module bus_read_fifo #(
    parameter logic [7:0] IO_ADDRESS = 8'hD8,
    parameter int         DEPTH      = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] BUS_ADDR,
    inout  wire  [7:0] BUS_DATA,
    input  logic       BUS_WE,
    input  logic       SRC_VALID,
    input  logic [7:0] SRC_DATA,
    output logic       SRC_READY,
    output logic       IRQ_RAISE,
    input  logic       IRQ_ACK
);

    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] STAT_ADDR = IO_ADDRESS + 8'd1;
    localparam logic [4:0] DEPTH_C   = 5'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]    count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          drv_q, drv_d;

    logic full, empty, rd_data, rd_stat, flush, pop, push;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == 5'd0);
    assign SRC_READY = ~full;

    // Bus decode: reads and the flush write are mutually exclusive via BUS_WE.
    assign rd_data = ~BUS_WE & (BUS_ADDR == IO_ADDRESS);
    assign rd_stat = ~BUS_WE & (BUS_ADDR == STAT_ADDR);
    assign flush   =  BUS_WE & (BUS_ADDR == STAT_ADDR);
    assign pop     = rd_data & ~empty;
    // A pop frees a slot in the same edge, so a full FIFO can still accept.
    assign push    = SRC_VALID & (~full | pop) & ~flush;

    // Next-state for pointers, count, overflow and the read response register.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        rdata_d  = rdata_q;
        drv_d    = rd_data | rd_stat;

        if (rd_data)
            rdata_d = empty ? 8'h00 : mem_q[rd_ptr_q];
        else if (rd_stat)
            rdata_d = {full, empty, ovf_q, 1'b0, count_q[3:0]};

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = AW'(wr_ptr_q + 1'b1);
            if (pop)  rd_ptr_d = AW'(rd_ptr_q + 1'b1);
            case ({push, pop})
                2'b10:   count_d = count_q + 5'd1;
                2'b01:   count_d = count_q - 5'd1;
                default: count_d = count_q;
            endcase
            if (SRC_VALID && full && !pop) ovf_d = 1'b1;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            rdata_q  <= 8'h00;
            drv_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            rdata_q  <= rdata_d;
            drv_q    <= drv_d;
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge CLK) begin
        if (!RESET && push) mem_q[wr_ptr_q] <= SRC_DATA;
    end

    assign BUS_DATA = drv_q ? rdata_q : 8'hzz;

`ifdef BUS_READ_FIFO_IRQ_EN
    logic irq_q, irq_d;

    // Raise on the empty-to-non-empty transition; a set wins over an ack.
    always_comb begin
        irq_d = irq_q;
        if (IRQ_ACK) irq_d = 1'b0;
        if (count_q == 5'd0 && count_d != 5'd0) irq_d = 1'b1;
    end

    // Interrupt request register.
    always_ff @(posedge CLK) begin
        if (RESET) irq_q <= 1'b0;
        else       irq_q <= irq_d;
    end

    assign IRQ_RAISE = irq_q;
`else
    logic unused_irq_ack;
    assign unused_irq_ack = IRQ_ACK;
    assign IRQ_RAISE      = 1'b0;
`endif

endmodule

// File: doc/bus_read_fifo.md
BUS_READ_FIFO -- requirements
Module: bus_read_fifo

Interface
REQ-001 Parameter IO_ADDRESS, default 8'hD8: base bus address; data port at IO_ADDRESS, status/control at IO_ADDRESS+1.
REQ-002 Parameter DEPTH, default 8: FIFO entries; power of two, 2..16.
REQ-003 CLK  input  1  clock; all state on rising edge.
REQ-004 RESET  input  1  reset, synchronous, active-high.
REQ-005 BUS_ADDR  input  8  processor bus address.
REQ-006 BUS_DATA  inout  8  processor bus data; driven by this block only per REQ-012, else high-Z.
REQ-007 BUS_WE  input  1  bus write strobe; 0 = read cycle.
REQ-008 SRC_VALID  input  1  source byte offered this cycle.
REQ-009 SRC_DATA  input  8  source byte.
REQ-010 SRC_READY  output  1  FIFO can accept; equals not-full.
REQ-011 IRQ_RAISE  output  1  interrupt request; IRQ_ACK  input  1  interrupt acknowledge.

Function
REQ-012 Read response registered: a cycle with BUS_WE=0 and BUS_ADDR in {IO_ADDRESS, IO_ADDRESS+1} loads an output register and asserts drive-enable at the next edge; BUS_DATA carries that register for exactly the following cycle, high-Z otherwise.
REQ-013 Each clock cycle with a data-port read counts as one read; the processor holds a read address for one cycle per access.
REQ-014 Data-port read, FIFO non-empty: returns head byte and pops in the same edge (read pointer +1 mod DEPTH, count -1).
REQ-015 Data-port read, FIFO empty: returns 8'h00, no pointer or count change.
REQ-016 Status read returns {full, empty, overflow, 0, count[3:0]}; no side effects.
REQ-017 Push: SRC_VALID=1 and (not full, or pop in same cycle) writes SRC_DATA at write pointer, pointer +1 mod DEPTH.
REQ-018 Simultaneous push and pop: both occur, count unchanged; allowed at full and at empty-with-pop-suppressed (empty: push only, read returns 8'h00).
REQ-019 SRC_VALID=1 while full and no pop: byte dropped, overflow flag set (sticky).
REQ-020 Bus write (BUS_WE=1) to IO_ADDRESS+1, any data: flush (pointers and count to 0), clear overflow; a push in the same cycle is dropped without setting overflow.
REQ-021 Bus write to IO_ADDRESS ignored; all other addresses ignored for read and write.
REQ-022 count width 5 bits; full = (count==DEPTH), empty = (count==0); pointers wrap modulo DEPTH.

Reset
REQ-023 RESET=1 at a rising edge: pointers, count, overflow, output register, drive-enable, IRQ_RAISE all 0; SRC_READY=1 next cycle.
REQ-024 Reset mid-read: drive-enable cleared, BUS_DATA high-Z the next cycle; FIFO contents lost.
REQ-025 Reset dominates all bus and source activity in the same cycle.

Configuration
REQ-026 Macro BUS_READ_FIFO_IRQ_EN defined: IRQ_RAISE set at the edge where count changes from 0 to non-zero, held until an edge with IRQ_ACK=1, which clears it; set and ack in the same cycle leaves it set.
REQ-027 Macro undefined: IRQ_RAISE constant 0, IRQ_ACK ignored, no interrupt logic synthesised; all other behaviour identical.

Verification
REQ-028 Push 8'hA1,8'hB2,8'hC3; read IO_ADDRESS three times -> BUS_DATA A1,B2,C3 each one cycle after address; status read then -> 8'h40.
REQ-029 Push 9 bytes with DEPTH=8, no reads -> SRC_READY=0 after 8th; status -> 8'hA8; 9th byte absent on subsequent 8 reads.
REQ-030 Full FIFO, SRC_VALID=1 with data-port read same cycle -> head returned, new byte stored, count stays 8, overflow stays 0.
REQ-031 Empty FIFO, data-port read -> BUS_DATA 8'h00 next cycle, status 8'h40; no-read cycles -> BUS_DATA high-Z.
REQ-032 4 bytes queued, overflow set, write 8'h00 to IO_ADDRESS+1 -> status 8'h40, next data read 8'h00.
REQ-033 With BUS_READ_FIFO_IRQ_EN: push to empty -> IRQ_RAISE=1 next cycle, stays 1 through further pushes, IRQ_ACK pulse -> 0; without macro IRQ_RAISE stays 0.
